// File: rtl/dma_csr_pkg.sv
// Shared types and constants for the DMA CSR bus master: FSM encoding,
// bus widths and the CSR register map offsets.
package dma_csr_pkg;

  localparam int unsigned CSR_ADDR_W = 4;
  localparam int unsigned CSR_DATA_W = 32;
  localparam int unsigned CSR_BE_W   = 4;

  localparam logic [CSR_ADDR_W-1:0] CSR_CONTROL_ADDR  = 4'h0;
  localparam logic [CSR_ADDR_W-1:0] CSR_STATUS_ADDR   = 4'h4;
  localparam logic [CSR_ADDR_W-1:0] CSR_NEXT_PTR_ADDR = 4'h8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

endpackage

// File: rtl/dma_csr_mst_timer.sv
// Wait-request timeout counter for dma_csr_master; only instantiated when
// DMA_CSR_MASTER_TIMEOUT_EN is defined.
module dma_csr_mst_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic tick_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == Limit);

  // Hold at the limit so a stale count can never wrap back below it.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_i && !expired_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dma_csr_master.sv
// Single-outstanding CSR bus master: accepts a command, runs one wait-request
// access and holds the response until it is taken. Timeout via DMA_CSR_MASTER_TIMEOUT_EN.
module dma_csr_master
  import dma_csr_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_wr_i,
  input  logic [CSR_ADDR_W-1:0] cmd_addr_i,
  input  logic [CSR_DATA_W-1:0] cmd_wr_data_i,
  input  logic [CSR_BE_W-1:0]   cmd_be_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [CSR_DATA_W-1:0] rsp_rd_data_o,
  output logic                  rsp_err_o,
  output logic                  csr_wr_o,
  output logic                  csr_rd_o,
  output logic [CSR_ADDR_W-1:0] csr_addr_o,
  output logic [CSR_DATA_W-1:0] csr_wr_data_o,
  output logic [CSR_BE_W-1:0]   csr_be_o,
  input  logic                  csr_wait_rq_i,
  input  logic [CSR_DATA_W-1:0] csr_rd_data_i,
  output logic                  busy_o
);

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e                state_q, state_d;
  logic                  csr_wr_q, csr_wr_d;
  logic                  csr_rd_q, csr_rd_d;
  logic [CSR_ADDR_W-1:0] addr_q, addr_d;
  logic [CSR_DATA_W-1:0] wdata_q, wdata_d;
  logic [CSR_BE_W-1:0]   be_q, be_d;
  logic [CSR_DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic                  accept;

  assign cmd_ready_o = (state_q == StIdle) & ~reset;
  assign accept      = cmd_valid_i & cmd_ready_o;

`ifdef DMA_CSR_MASTER_TIMEOUT_EN
  logic timeout_hit;
  logic rsp_err_q, rsp_err_d;

  dma_csr_mst_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (accept),
    .tick_i   ((state_q == StAccess) & csr_wait_rq_i),
    .expired_o(timeout_hit)
  );

  assign rsp_err_o = rsp_err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    csr_wr_d   = csr_wr_q;
    csr_rd_d   = csr_rd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rsp_data_d = rsp_data_q;
`ifdef DMA_CSR_MASTER_TIMEOUT_EN
    rsp_err_d  = rsp_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          csr_wr_d = cmd_wr_i;
          csr_rd_d = ~cmd_wr_i;
          addr_d   = cmd_addr_i;
          wdata_d  = cmd_wr_data_i;
          be_d     = cmd_be_i;
          state_d  = StAccess;
        end
      end
      StAccess: begin
        // Completion is checked first so it wins over a same-cycle timeout.
        if (!csr_wait_rq_i) begin
          rsp_data_d = csr_rd_q ? csr_rd_data_i : '0;
          csr_wr_d   = 1'b0;
          csr_rd_d   = 1'b0;
          state_d    = StResp;
`ifdef DMA_CSR_MASTER_TIMEOUT_EN
          rsp_err_d  = 1'b0;
        end else if (timeout_hit) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          csr_wr_d   = 1'b0;
          csr_rd_d   = 1'b0;
          state_d    = StResp;
`endif
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      csr_wr_q   <= 1'b0;
      csr_rd_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rsp_data_q <= '0;
`ifdef DMA_CSR_MASTER_TIMEOUT_EN
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      csr_wr_q   <= csr_wr_d;
      csr_rd_q   <= csr_rd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      rsp_data_q <= rsp_data_d;
`ifdef DMA_CSR_MASTER_TIMEOUT_EN
      rsp_err_q  <= rsp_err_d;
`endif
    end
  end

  assign csr_wr_o      = csr_wr_q;
  assign csr_rd_o      = csr_rd_q;
  assign csr_addr_o    = addr_q;
  assign csr_wr_data_o = wdata_q;
  assign csr_be_o      = be_q;
  assign rsp_valid_o   = (state_q == StResp);
  assign rsp_rd_data_o = rsp_data_q;
  assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_dma_csr_master.sv
// Directed bench for dma_csr_master against a small wait-request register-file
// slave; timeout checks follow DMA_CSR_MASTER_TIMEOUT_EN.
module tb_dma_csr_master;

  logic        clk;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [3:0]  cmd_addr, cmd_be;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic        csr_wr, csr_rd, wait_rq, busy;
  logic [3:0]  csr_addr, csr_be;
  logic [31:0] csr_wdata, csr_rdata;

  int n_pass = 0;
  int n_total = 0;

  dma_csr_master #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_wr_i     (cmd_wr),
    .cmd_addr_i   (cmd_addr),
    .cmd_wr_data_i(cmd_wdata),
    .cmd_be_i     (cmd_be),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rd_data_o(rsp_data),
    .rsp_err_o    (rsp_err),
    .csr_wr_o     (csr_wr),
    .csr_rd_o     (csr_rd),
    .csr_addr_o   (csr_addr),
    .csr_wr_data_o(csr_wdata),
    .csr_be_o     (csr_be),
    .csr_wait_rq_i(wait_rq),
    .csr_rd_data_i(csr_rdata),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave: raises wait for the first slave_wait_len cycles of each access.
  logic [31:0] regs [16];
  int          slv_cnt = 0;
  int          slave_wait_len;
  logic        slv_clr;
  logic        slv_strobe;

  assign slv_strobe = csr_wr | csr_rd;
  assign wait_rq    = slv_strobe && (slv_cnt < slave_wait_len);
  assign csr_rdata  = wait_rq ? 32'hBAD0_BAD0 : regs[csr_addr];

  always @(posedge clk) begin
    if (!slv_strobe) slv_cnt <= 0;
    else             slv_cnt <= slv_cnt + 1;
    if (slv_clr) begin
      for (int i = 0; i < 16; i++) regs[i] <= 32'h0;
    end else if (csr_wr && !wait_rq) begin
      for (int b = 0; b < 4; b++)
        if (csr_be[b]) regs[csr_addr][8*b +: 8] <= csr_wdata[8*b +: 8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic wait_handshake(input string name);
    int n = 0;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    check({name, " rsp arrives"}, rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // Issue one command and watch it until a response or the budget expires.
  task automatic run_access(input logic wr, input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] be, input int budget,
                            output logic [31:0] rdata, output logic err, output int strobes,
                            output int lat, output logic stable, output logic got);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = data; cmd_be = be;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check("cmd accepted", cmd_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    strobes = 0; lat = 0; got = 1'b0; stable = 1'b1; rdata = 32'hX; err = 1'bX;
    for (int k = 1; k <= budget; k++) begin
      if (csr_wr || csr_rd) begin
        strobes++;
        if (csr_wr !== wr || csr_rd !== !wr || csr_addr !== addr || csr_wdata !== data ||
            csr_be !== be) stable = 1'b0;
      end
      if (rsp_valid) begin
        if (csr_wr || csr_rd) stable = 1'b0;
        got = 1'b1; lat = k; rdata = rsp_data; err = rsp_err;
        break;
      end
      @(negedge clk);
    end
    if (got) begin
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          wait_len;
    logic [31:0] exp_rdata;
    int          exp_strobes;
    int          exp_lat;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] rd;
  logic        er, st, got;
  int          sb, lt, seen;

  initial begin
    vecs[0] = '{1'b1, 4'h0, 32'hDEAD_BEEF, 4'hF, 1, 32'h0,         2, 3};
    vecs[1] = '{1'b0, 4'h0, 32'h0,         4'hF, 1, 32'hDEAD_BEEF, 2, 3};
    vecs[2] = '{1'b1, 4'h8, 32'h1122_3344, 4'hF, 1, 32'h0,         2, 3};
    vecs[3] = '{1'b1, 4'h8, 32'h0000_AB00, 4'h2, 1, 32'h0,         2, 3};
    vecs[4] = '{1'b0, 4'h8, 32'h0,         4'hF, 1, 32'h1122_AB44, 2, 3};
    vecs[5] = '{1'b1, 4'hF, 32'hA5A5_A5A5, 4'h9, 1, 32'h0,         2, 3};
    vecs[6] = '{1'b0, 4'hF, 32'h0,         4'hF, 5, 32'hA500_00A5, 6, 7};
    vecs[7] = '{1'b0, 4'h4, 32'h0,         4'hF, 1, 32'h0,         2, 3};

    reset = 1'b1; cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 4'h8;
    cmd_wdata = 32'hFFFF_FFFF; cmd_be = 4'hF; rsp_ready = 1'b0;
    slv_clr = 1'b1; slave_wait_len = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ctl outputs", {26'd0, cmd_ready, busy, rsp_valid, rsp_err, csr_wr, csr_rd}, 0);
    check("reset addr/be", {24'd0, csr_addr, csr_be}, 0);
    check("reset wr_data", csr_wdata, 0);
    check("reset rsp_data", rsp_data, 0);
    reset = 1'b0; cmd_valid = 1'b0; slv_clr = 1'b0;
    @(negedge clk);
    check("idle after reset", {busy, cmd_ready}, 2'b01);

    for (int i = 0; i < 8; i++) begin
      slave_wait_len = vecs[i].wait_len;
      run_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, 100, rd, er, sb, lt, st,
                 got);
      check($sformatf("vec%0d got rsp", i), got, 1'b1);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d err", i), er, 1'b0);
      check($sformatf("vec%0d strobe cycles", i), sb, vecs[i].exp_strobes);
      check($sformatf("vec%0d latency", i), lt, vecs[i].exp_lat);
      check($sformatf("vec%0d csr stable", i), st, 1'b1);
    end

    // Response back-pressure with a second command pending.
    slave_wait_len = 1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'h8; cmd_wdata = 32'h0; cmd_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cmd_wr = 1'b1; cmd_addr = 4'h4; cmd_wdata = 32'h0000_0055;
    seen = 0;
    while (!rsp_valid && seen < 20) begin @(negedge clk); seen++; end
    st = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (!rsp_valid || rsp_data !== 32'h1122_AB44 || rsp_err || cmd_ready || !busy) st = 1'b0;
      @(negedge clk);
    end
    check("bp rsp held, cmd blocked", st, 1'b1);
    check("bp rsp data", rsp_data, 32'h1122_AB44);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp ready after handshake", {busy, cmd_ready}, 2'b01);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("bp second cmd issued", {27'd0, csr_wr, csr_rd, csr_addr}, {27'd0, 2'b10, 4'h4});
    wait_handshake("bp second");
    run_access(1'b0, 4'h4, 32'h0, 4'hF, 100, rd, er, sb, lt, st, got);
    check("bp readback", rd, 32'h0000_0055);

    // Reset in the middle of an access.
    slave_wait_len = 5;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'h0; cmd_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("mid access strobe", csr_rd, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset abort outputs", {28'd0, csr_wr, csr_rd, rsp_valid, busy}, 0);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("no rsp after abort", seen, 0);
    slave_wait_len = 1;
    run_access(1'b0, 4'h0, 32'h0, 4'hF, 100, rd, er, sb, lt, st, got);
    check("post reset read", rd, 32'hDEAD_BEEF);
    check("post reset latency", lt, 3);

`ifdef DMA_CSR_MASTER_TIMEOUT_EN
    // Wait drops exactly when the limit is reached: completion wins.
    slave_wait_len = 7;
    run_access(1'b0, 4'h8, 32'h0, 4'hF, 100, rd, er, sb, lt, st, got);
    check("edge rdata", rd, 32'h1122_AB44);
    check("edge err", er, 1'b0);
    check("edge strobes", sb, 8);
    slave_wait_len = 1000;
    run_access(1'b0, 4'h8, 32'h0, 4'hF, 100, rd, er, sb, lt, st, got);
    check("timeout got rsp", got, 1'b1);
    check("timeout err", er, 1'b1);
    check("timeout data", rd, 32'h0);
    check("timeout strobes", sb, 8);
    check("timeout latency", lt, 9);
`else
    slave_wait_len = 1000;
    run_access(1'b0, 4'h8, 32'h0, 4'hF, 100, rd, er, sb, lt, st, got);
    check("no timeout rsp", got, 1'b0);
    check("no timeout strobes", sb, 100);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
`endif
    slave_wait_len = 1;
    run_access(1'b0, 4'h8, 32'h0, 4'hF, 100, rd, er, sb, lt, st, got);
    check("final read", rd, 32'h1122_AB44);
    check("final err", er, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
